// File: rtl/word_serializer_pkg.sv
// Shared definitions for the word serializer: FSM state encoding,
// default frame geometry and counter sizing.
package word_serializer_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_GAP   = 7;
    localparam int GAP_CNT_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Bits needed to count 0..width inclusive.
    function automatic int bit_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/word_serializer.sv
// Parallel-to-serial converter: accepts one word in IDLE, shifts it out MSB
// first with start/finish markers, then holds off for GAP idle cycles.
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int GAP   = DEFAULT_GAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    input  logic             valid,
    output logic             ready,
    output logic             in_bit,
    output logic             start,
    output logic             finish,
    output logic             busy
);

    localparam int CNT_W = bit_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(WIDTH);
    localparam logic [GAP_CNT_W-1:0] LAST_GAP = GAP_CNT_W'(GAP);

    state_t               state_reg, state_next;
    logic [WIDTH-1:0]     shift_reg, shift_next;
    logic [CNT_W-1:0]     bit_cnt_reg, bit_cnt_next;
    logic [GAP_CNT_W-1:0] gap_cnt_reg, gap_cnt_next;
    logic                 in_bit_reg, in_bit_next;
    logic                 start_reg, start_next;
    logic                 finish_reg, finish_next;
    logic                 busy_reg, busy_next;

    assign ready  = (state_reg == ST_IDLE);
    assign in_bit = in_bit_reg;
    assign start  = start_reg;
    assign finish = finish_reg;
    assign busy   = busy_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            gap_cnt_reg <= '0;
            in_bit_reg  <= 1'b0;
            start_reg   <= 1'b0;
            finish_reg  <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            gap_cnt_reg <= gap_cnt_next;
            in_bit_reg  <= in_bit_next;
            start_reg   <= start_next;
            finish_reg  <= finish_next;
            busy_reg    <= busy_next;
        end
    end

    // bit_cnt_reg holds the number of bits already presented on in_bit,
    // so the MSB goes out straight from the accept edge with no bubble.
    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        gap_cnt_next = gap_cnt_reg;
        in_bit_next  = 1'b0;
        start_next   = 1'b0;
        finish_next  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (valid && ready) begin
                    state_next   = ST_SHIFT;
                    shift_next   = data << 1;
                    in_bit_next  = data[WIDTH-1];
                    start_next   = 1'b1;
                    finish_next  = (LAST_BIT == CNT_W'(1));
                    bit_cnt_next = CNT_W'(1);
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_reg == LAST_BIT) begin
                    shift_next   = '0;
                    bit_cnt_next = '0;
                    if (GAP == 0) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next   = ST_GAP;
                        gap_cnt_next = GAP_CNT_W'(1);
                    end
                end else begin
                    in_bit_next  = shift_reg[WIDTH-1];
                    shift_next   = shift_reg << 1;
                    bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                    finish_next  = ((bit_cnt_reg + CNT_W'(1)) == LAST_BIT);
                end
            end
            ST_GAP: begin
                if (gap_cnt_reg == LAST_GAP) begin
                    state_next   = ST_IDLE;
                    gap_cnt_next = '0;
                end else begin
                    gap_cnt_next = gap_cnt_reg + GAP_CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        busy_next = (state_next != ST_IDLE);
    end

endmodule
